// File: rtl/match_window_counter_if.sv
// Result port of match_window_counter: per-window match count with a valid/ready handshake.
interface match_window_counter_if #(
  parameter int unsigned CNT_W = 5
);
  logic [CNT_W-1:0] cnt_data;
  logic             cnt_valid;
  logic             cnt_ready;

  modport master (output cnt_data, output cnt_valid, input cnt_ready);
  modport slave  (input cnt_data, input cnt_valid, output cnt_ready);
endinterface

// File: rtl/match_window_counter.sv
// Counts detector match pulses over fixed WIN_CYCLES windows and hands each total downstream.
// Optional MATCH_ALARM_EN adds a sticky alarm for windows whose total reaches ALARM_THR.
module match_window_counter #(
  parameter int unsigned WIN_CYCLES = 16,
  parameter int unsigned CNT_W      = 5
`ifdef MATCH_ALARM_EN
  ,
  parameter logic [CNT_W-1:0] ALARM_THR = CNT_W'(2)
`endif
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   en,
  input  logic                   match_in,
  match_window_counter_if.master res,
  output logic                   overrun,
  input  logic                   clr_ovr
`ifdef MATCH_ALARM_EN
  ,
  output logic                   alarm
`endif
);

  localparam int unsigned WIN_W = $clog2(WIN_CYCLES);
  localparam logic [WIN_W-1:0] WinLast = WIN_W'(WIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntMax  = '1;

  typedef enum logic [0:0] {StIdle, StCount} state_e;

  state_e           state_q, state_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0] cnt_data_q, cnt_data_d;
  logic             cnt_valid_q, cnt_valid_d;
  logic             overrun_q, overrun_d;

  logic             win_close;
  logic             xfer;
  logic [CNT_W-1:0] result;

  assign win_close = (state_q == StCount) && (win_cnt_q == WinLast);
  assign xfer      = cnt_valid_q && res.cnt_ready;
  // Running count including this cycle's match, saturated.
  assign result    = (match_in && (run_cnt_q != CntMax)) ? run_cnt_q + 1'b1 : run_cnt_q;

  always_comb begin
    state_d   = state_q;
    win_cnt_d = '0;
    run_cnt_d = '0;
    unique case (state_q)
      StIdle: begin
        if (en) state_d = StCount;
      end
      StCount: begin
        if (win_close) begin
          state_d = en ? StCount : StIdle;
        end else if (!en) begin
          state_d = StIdle;
        end else begin
          win_cnt_d = win_cnt_q + 1'b1;
          run_cnt_d = result;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_data_d  = cnt_data_q;
    cnt_valid_d = cnt_valid_q;
    overrun_d   = overrun_q;
    if (clr_ovr) overrun_d = 1'b0;
    if (win_close) begin
      if (!cnt_valid_q || xfer) begin
        cnt_data_d  = result;
        cnt_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (xfer) begin
      cnt_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      win_cnt_q   <= '0;
      run_cnt_q   <= '0;
      cnt_data_q  <= '0;
      cnt_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_cnt_q   <= win_cnt_d;
      run_cnt_q   <= run_cnt_d;
      cnt_data_q  <= cnt_data_d;
      cnt_valid_q <= cnt_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign res.cnt_data  = cnt_data_q;
  assign res.cnt_valid = cnt_valid_q;
  assign overrun       = overrun_q;

`ifdef MATCH_ALARM_EN
  logic alarm_q, alarm_d;

  // Dropped results still count towards the alarm.
  always_comb begin
    alarm_d = alarm_q;
    if (clr_ovr) alarm_d = 1'b0;
    if (win_close && (result >= ALARM_THR)) alarm_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) alarm_q <= 1'b0;
    else       alarm_q <= alarm_d;
  end

  assign alarm = alarm_q;
`endif

endmodule

// File: doc/match_window_counter.md
Name: match_window_counter

Overview:
- Downstream consumer of the 1011 sequence detector's single-bit match output.
- Counts match pulses over fixed windows of WIN_CYCLES clocks.
- Presents each window's total on a valid/ready result port, with a sticky overrun flag for dropped results.
- Sits between the detector and the status/CSR logic that collects match statistics.

Parameters:
- WIN_CYCLES, 16, window length in clocks; legal range is WIN_CYCLES >= 2.
- CNT_W, 5, width of the match count; the count saturates at 2^CNT_W-1.
- WIN_W, $clog2(WIN_CYCLES), width of the internal window counter; derived, never overridden.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rstn  input  1  reset, asynchronous, active-low.
- en  input  1  level; 1 enables window counting, 0 returns the block to IDLE.
- match_in  input  1  match pulse from the detector; each high cycle counts as one match.
- cnt_data  output  CNT_W  registered match count of the last completed window.
- cnt_valid  output  1  cnt_data holds an unconsumed result.
- cnt_ready  input  1  downstream accepts cnt_data when cnt_valid=1.
- overrun  output  1  sticky; set when a completed window's result was dropped.
- clr_ovr  input  1  single-cycle pulse that clears overrun.

Behaviour:
- Reset (rstn=0, takes effect immediately without waiting for clk):
  - state=IDLE, win_cnt=0, run_cnt=0.
  - cnt_data=0, cnt_valid=0, overrun=0.
- FSM states are IDLE and COUNT.
- IDLE:
  - match_in is ignored; win_cnt=0, run_cnt=0.
  - en=1 -> COUNT on the next edge. The first counting cycle is the cycle after en is sampled high.
- COUNT, every cycle:
  - win_cnt increments.
  - If match_in=1, run_cnt increments, saturating at 2^CNT_W-1 with no wrap.
- Window close (COUNT and win_cnt==WIN_CYCLES-1):
  - The result is run_cnt plus match_in, saturated. A match on the last window cycle is counted.
  - win_cnt and run_cnt return to 0.
  - Stays in COUNT if en=1; goes to IDLE if en=0.
- en=0 in COUNT before window close -> IDLE on the next edge. The partial window is discarded and no result is produced.
- Result register handshake:
  - A transfer happens when cnt_valid=1 and cnt_ready=1. On a transfer with no window close in the same cycle, cnt_valid goes to 0 next cycle.
  - Window close with cnt_valid=0 -> cnt_data=result and cnt_valid=1 next cycle. Latency is one clock after the last window cycle.
  - Window close in the same cycle as a transfer -> the new result is loaded and cnt_valid stays 1.
  - Window close with cnt_valid=1 and no transfer -> the new result is dropped, cnt_data is unchanged, and overrun=1 next cycle.
- cnt_data and cnt_valid are unaffected by en. A pending result survives en=0 and remains until consumed.
- overrun:
  - Cleared by clr_ovr=1.
  - If a set condition and clr_ovr occur in the same cycle, the set wins.
- Match pulses on adjacent cycles each count; no edge detection is applied.

Optional Feature:
- Macro: MATCH_ALARM_EN.
- When defined, the block adds:
  - parameter ALARM_THR (default 2, CNT_W bits);
  - output alarm (1 bit, reset 0).
- alarm behaviour:
  - Sets on any window close whose result is >= ALARM_THR. This includes a result that is dropped due to overrun.
  - alarm is sticky and is cleared by clr_ovr; a set in the same cycle as the clear wins.
- When not defined, the ALARM_THR parameter, the alarm port and the alarm logic are all absent. The rest of the behaviour is identical.

Test Plan:
1. Async reset: drive rstn=0 mid-window with cnt_valid=1 and overrun=1 -> cnt_data=0, cnt_valid=0 and overrun=0 before the next clk edge. After release, the block stays in IDLE until en=1.
2. Basic window (defaults): en=1, cnt_ready=1, match_in pulses on counting cycles 3, 7 and 11 -> cnt_valid=1 for exactly one cycle, one clock after counting cycle 15 (the 16th), with cnt_data=3. The next window starts immediately and cnt_data=0 for an empty window.
3. Last-cycle match and saturation (CNT_W=2, WIN_CYCLES=8):
   - match_in=1 on all 8 cycles -> cnt_data=3, saturated.
   - match_in=1 only on cycle 7 -> cnt_data=1.
4. Backpressure: hold cnt_ready=0 over 2 windows with 2 and then 4 matches -> cnt_data stays 2 and overrun=1. Then cnt_ready=1 -> one transfer of 2, cnt_valid=0. Then clr_ovr pulse -> overrun=0.
5. Abort and simultaneous events:
   - en=0 on counting cycle 8 with 2 matches counted -> no cnt_valid. en=1 again -> a fresh window that counts only new matches.
   - Window close coinciding with a transfer -> new value loaded, cnt_valid stays 1, overrun stays 0.
6. MATCH_ALARM_EN with ALARM_THR=2:
   - A window with 2 matches -> alarm=1 and stays 1.
   - clr_ovr pulse -> alarm=0.
   - A window with 1 match -> alarm stays 0.
